// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the FIR address sequencer.
//   ADDR_W : sample address / sample count / output address width
//   TAPS   : number of filter taps (power of two)
//   TAP_W  : coefficient address width, log2(TAPS)
//   RD_LAT : cycles from tr_ld to read data valid at the MAC
package fir_pkg;
  localparam int ADDR_W = 13;
  localparam int TAPS   = 64;
  localparam int TAP_W  = 6;
  localparam int RD_LAT = 2;

  typedef enum logic [2:0] {IDLE, TAP, DRAIN, WRITE, DONE} state_t;
endpackage

// File: rtl/fir_vld_pipe.sv
// Delay line carrying {load, first-tap} from the address issue point to the
// MAC, matching the address-register + RAM read latency.
//   clk, rst    : clock, async active-high reset (clears the pipe)
//   i_ld        : tap issued this cycle
//   i_first     : issued tap is k==0
//   o_mac_en    : i_ld delayed by DEPTH cycles
//   o_acc_clr   : i_first delayed by DEPTH cycles
module fir_vld_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ld,
  input  logic i_first,
  output logic o_mac_en,
  output logic o_acc_clr
);
  logic [DEPTH-1:0][1:0] r_vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= {i_ld, i_first};
      for (int i = 1; i < DEPTH; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  assign o_mac_en  = r_vld_pipe[DEPTH-1][1];
  assign o_acc_clr = r_vld_pipe[DEPTH-1][0];
endmodule

// File: rtl/fir_addr_seq.sv
// FIR convolution address sequencer. Walks n over 0..N-1 and, for each n,
// k over 0..min(n,TAPS-1), issuing sample address n-k and coefficient
// address k. After the last tap it waits RD_LAT cycles for the MAC to
// absorb the final product, then pulses out_wr for y[n].
//   clk, rst   : clock, async active-high reset
//   start      : begin a run (only looked at in IDLE)
//   n_samples  : sample count N, latched on accepted start
//   tr_ld      : address register load strobe
//   tr_addr    : sample address n-k
//   coef_addr  : tap index k
//   mac_en     : accumulate enable (tr_ld delayed RD_LAT)
//   acc_clr    : first-tap marker aligned with mac_en
//   out_wr     : result write strobe
//   out_addr   : result index n
//   busy       : not IDLE
//   done       : one-cycle end-of-run pulse
module fir_addr_seq
  import fir_pkg::*;
#(
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int TAPS   = fir_pkg::TAPS,
  parameter int TAP_W  = fir_pkg::TAP_W,
  parameter int RD_LAT = fir_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_samples,
  output logic              tr_ld,
  output logic [ADDR_W-1:0] tr_addr,
  output logic [TAP_W-1:0]  coef_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);
  localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_n, r_nsamp;
  logic [TAP_W-1:0]  r_k;
  logic [DRN_W-1:0]  r_drn;

  logic [TAP_W-1:0]  w_kmax;
  logic              w_k_last, w_n_last, w_drn_last, w_first;

  // Early results see fewer than TAPS samples; stopping at k==n gives the
  // implicit zero padding and keeps n-k from underflowing.
  assign w_kmax     = (r_n >= ADDR_W'(TAPS-1)) ? TAP_W'(TAPS-1) : r_n[TAP_W-1:0];
  assign w_k_last   = (r_k == w_kmax);
  assign w_n_last   = (r_n == r_nsamp - ADDR_W'(1));
  assign w_drn_last = (r_drn == DRN_W'(RD_LAT-1));
  assign w_first    = (r_state == TAP) && (r_k == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    tr_ld     = 1'b0;
    tr_addr   = '0;
    coef_addr = '0;
    out_wr    = 1'b0;
    out_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_nxt = (n_samples == '0) ? DONE : TAP;
      end
      TAP: begin
        tr_ld     = 1'b1;
        tr_addr   = r_n - ADDR_W'(r_k);
        coef_addr = r_k;
        if (w_k_last) w_nxt = DRAIN;
      end
      DRAIN: if (w_drn_last) w_nxt = WRITE;
      WRITE: begin
        out_wr   = 1'b1;
        out_addr = r_n;
        w_nxt    = w_n_last ? DONE : TAP;
      end
      DONE: begin
        done  = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n     <= '0;
      r_k     <= '0;
      r_nsamp <= '0;
      r_drn   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_nsamp <= n_samples;
          r_n     <= '0;
          r_k     <= '0;
          r_drn   <= '0;
        end
        TAP:   r_k <= w_k_last ? '0 : r_k + TAP_W'(1);
        DRAIN: r_drn <= w_drn_last ? '0 : r_drn + DRN_W'(1);
        WRITE: if (!w_n_last) r_n <= r_n + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  fir_vld_pipe #(.DEPTH(RD_LAT)) u_vld_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_ld      (tr_ld),
    .i_first   (w_first),
    .o_mac_en  (mac_en),
    .o_acc_clr (acc_clr)
  );
endmodule

// File: tb/tb_fir_addr_seq.sv
module tb_fir_addr_seq;
  localparam int AW = 13, TP = 4, TW = 2, RL = 2;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] n_samples = '0;
  logic          tr_ld, mac_en, acc_clr, out_wr, busy, done;
  logic [AW-1:0] tr_addr, out_addr;
  logic [TW-1:0] coef_addr;

  fir_addr_seq #(.ADDR_W(AW), .TAPS(TP), .TAP_W(TW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .tr_ld(tr_ld), .tr_addr(tr_addr), .coef_addr(coef_addr),
    .mac_en(mac_en), .acc_clr(acc_clr), .out_wr(out_wr),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Event log sampled on the falling edge.
  int c_ld = 0, c_clr = 0, c_mac = 0, c_wr = 0, c_done = 0;
  int q_addr[$], q_coef[$], q_oaddr[$];
  always @(negedge clk) begin
    if (tr_ld) begin
      c_ld <= c_ld + 1;
      q_addr.push_back(int'(tr_addr));
      q_coef.push_back(int'(coef_addr));
    end
    if (acc_clr) c_clr <= c_clr + 1;
    if (mac_en)  c_mac <= c_mac + 1;
    if (out_wr) begin
      c_wr <= c_wr + 1;
      q_oaddr.push_back(int'(out_addr));
    end
    if (done) c_done <= c_done + 1;
  end

  int n_pass = 0, n_tot = 0;
  int b_ld, b_clr, b_mac, b_wr, b_done, bq, bo, cyc;

  int e3a[6] = '{0, 1, 0, 2, 1, 0};
  int e3c[6] = '{0, 0, 1, 0, 1, 2};
  int e6a[4] = '{5, 4, 3, 2};
  int e2a[3] = '{0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic snap;
    b_ld = c_ld; b_clr = c_clr; b_mac = c_mac; b_wr = c_wr; b_done = c_done;
    bq = q_addr.size(); bo = q_oaddr.size();
  endtask

  // Start presented in cycle 0; returns in cycle 1.
  task automatic launch(input int n);
    n_samples = AW'(n);
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, output int c);
    c = c0;
    while (done !== 1'b1 && c < budget) begin
      step;
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step; step;
    chk("rst_tr_ld", tr_ld, 0);
    chk("rst_tr_addr", tr_addr, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step;
    chk("idle_busy", busy, 0);

    // N=1, cycle-exact
    launch(1);                                   // cycle 1
    chk("n1_c1_ld", tr_ld, 1);
    chk("n1_c1_addr", tr_addr, 0);
    chk("n1_c1_coef", coef_addr, 0);
    chk("n1_c1_busy", busy, 1);
    chk("n1_c1_mac", mac_en, 0);
    step;                                        // cycle 2
    chk("n1_c2_ld", tr_ld, 0);
    chk("n1_c2_mac", mac_en, 0);
    step;                                        // cycle 3
    chk("n1_c3_mac", mac_en, 1);
    chk("n1_c3_clr", acc_clr, 1);
    chk("n1_c3_wr", out_wr, 0);
    step;                                        // cycle 4
    chk("n1_c4_wr", out_wr, 1);
    chk("n1_c4_oaddr", out_addr, 0);
    chk("n1_c4_mac", mac_en, 0);
    step;                                        // cycle 5
    chk("n1_c5_done", done, 1);
    chk("n1_c5_busy", busy, 1);
    step;                                        // cycle 6
    chk("n1_c6_done", done, 0);
    chk("n1_c6_busy", busy, 0);

    // N=3, TAPS=4: triangular start-up
    snap;
    launch(3);
    wait_done(1, 200, cyc);
    chk("n3_done_cyc", cyc, 16);
    step;
    chk("n3_ld_cnt", c_ld - b_ld, 6);
    chk("n3_clr_cnt", c_clr - b_clr, 3);
    chk("n3_mac_cnt", c_mac - b_mac, 6);
    chk("n3_wr_cnt", c_wr - b_wr, 3);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("n3_addr%0d", i), q_addr[bq+i], e3a[i]);
      chk($sformatf("n3_coef%0d", i), q_coef[bq+i], e3c[i]);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("n3_oaddr%0d", i), q_oaddr[bo+i], i);

    // N=6, TAPS=4: full-width taps once n>=3
    snap;
    launch(6);
    wait_done(1, 200, cyc);
    chk("n6_done_cyc", cyc, 37);
    step;
    chk("n6_ld_cnt", c_ld - b_ld, 18);
    chk("n6_wr_cnt", c_wr - b_wr, 6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("n6_y5_addr%0d", i), q_addr[bq+14+i], e6a[i]);
      chk($sformatf("n6_y5_coef%0d", i), q_coef[bq+14+i], i);
    end
    chk("n6_last_oaddr", q_oaddr[bo+5], 5);

    // N=0: straight to DONE
    snap;
    launch(0);
    wait_done(1, 50, cyc);
    chk("n0_done_cyc", cyc, 1);
    step;
    chk("n0_ld_cnt", c_ld - b_ld, 0);
    chk("n0_wr_cnt", c_wr - b_wr, 0);
    chk("n0_busy", busy, 0);

    // start pulsed mid-run with another N
    snap;
    launch(3);
    repeat (4) step;                             // cycle 5
    n_samples = AW'(5);
    start = 1'b1;
    step;                                        // cycle 6
    start = 1'b0;
    wait_done(6, 200, cyc);
    chk("mid_done_cyc", cyc, 16);
    repeat (10) step;
    chk("mid_done_cnt", c_done - b_done, 1);
    chk("mid_wr_cnt", c_wr - b_wr, 3);
    chk("mid_ld_cnt", c_ld - b_ld, 6);
    chk("mid_busy", busy, 0);

    // reset during DRAIN
    snap;
    launch(2);                                   // cycle 1: tap n=0
    step; step;                                  // cycle 3: DRAIN, mac_en up
    chk("pre_rst_mac", mac_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mac", mac_en, 0);
    chk("rst_mid_clr", acc_clr, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ld", tr_ld, 0);
    chk("rst_mid_wr", out_wr, 0);
    chk("rst_mid_done", done, 0);
    step;
    rst = 1'b0;
    step; step;
    chk("rst_mid_no_done", c_done - b_done, 0);
    chk("rst_mid_no_wr", c_wr - b_wr, 0);
    chk("rst_mid_pipe_clr", mac_en, 0);

    // clean run after reset
    snap;
    launch(2);
    wait_done(1, 200, cyc);
    chk("post_done_cyc", cyc, 10);
    step;
    chk("post_ld_cnt", c_ld - b_ld, 3);
    chk("post_clr_cnt", c_clr - b_clr, 2);
    for (int i = 0; i < 3; i++) chk($sformatf("post_addr%0d", i), q_addr[bq+i], e2a[i]);
    for (int i = 0; i < 2; i++) chk($sformatf("post_oaddr%0d", i), q_oaddr[bo+i], i);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
